// File: rtl/button_press_encoder.sv
// Push-button front end: synchronises and debounces a raw button level, then emits
// single-cycle press / long-hold / auto-repeat pulses and a wrapping press counter.
module button_press_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LONG_CYCLES     = 16,
  parameter int REPEAT_CYCLES   = 8,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_raw,
  output logic             btn_level,
  output logic             press_pulse,
  output logic             long_pulse,
  output logic             repeat_pulse,
  output logic [CNT_W-1:0] press_count
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam int REP_W  = $clog2(REPEAT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DB_PRESS,
    S_HELD,
    S_LONG,
    S_DB_RELEASE
  } state_t;

  logic              r_sync1;
  logic              r_btn_s;
  state_t            r_state, w_state_next;
  state_t            r_ret, w_ret_next;
  logic [DB_W-1:0]   r_db_cnt, w_db_cnt_next;
  logic [HOLD_W-1:0] r_hold_cnt, w_hold_cnt_next;
  logic [REP_W-1:0]  r_rep_cnt, w_rep_cnt_next;
  logic              r_level, w_level_next;
  logic              r_press, w_press_next;
  logic              r_long, w_long_next;
  logic              r_repeat, w_repeat_next;
  logic [CNT_W-1:0]  r_count, w_count_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= 1'b0;
      r_btn_s    <= 1'b0;
      r_state    <= S_IDLE;
      r_ret      <= S_HELD;
      r_db_cnt   <= '0;
      r_hold_cnt <= '0;
      r_rep_cnt  <= '0;
      r_level    <= 1'b0;
      r_press    <= 1'b0;
      r_long     <= 1'b0;
      r_repeat   <= 1'b0;
      r_count    <= '0;
    end else begin
      r_sync1    <= btn_raw;
      r_btn_s    <= r_sync1;
      r_state    <= w_state_next;
      r_ret      <= w_ret_next;
      r_db_cnt   <= w_db_cnt_next;
      r_hold_cnt <= w_hold_cnt_next;
      r_rep_cnt  <= w_rep_cnt_next;
      r_level    <= w_level_next;
      r_press    <= w_press_next;
      r_long     <= w_long_next;
      r_repeat   <= w_repeat_next;
      r_count    <= w_count_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_ret_next      = r_ret;
    w_db_cnt_next   = r_db_cnt;
    w_hold_cnt_next = r_hold_cnt;
    w_rep_cnt_next  = r_rep_cnt;
    w_level_next    = r_level;
    w_press_next    = 1'b0;
    w_long_next     = 1'b0;
    w_repeat_next   = 1'b0;
    w_count_next    = r_count;

    case (r_state)
      S_IDLE: begin
        if (r_btn_s) begin
          w_state_next  = S_DB_PRESS;
          w_db_cnt_next = '0;
        end
      end
      S_DB_PRESS: begin
        // A low sample anywhere in the window rejects the press outright.
        if (!r_btn_s) begin
          w_state_next = S_IDLE;
        end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          w_state_next    = S_HELD;
          w_level_next    = 1'b1;
          w_press_next    = 1'b1;
          w_count_next    = r_count + CNT_W'(1);
          w_hold_cnt_next = '0;
        end else begin
          w_db_cnt_next = r_db_cnt + DB_W'(1);
        end
      end
      S_HELD: begin
        if (!r_btn_s) begin
          w_state_next  = S_DB_RELEASE;
          w_ret_next    = S_HELD;
          w_db_cnt_next = '0;
        end else if (r_hold_cnt == HOLD_W'(LONG_CYCLES - 1)) begin
          w_state_next   = S_LONG;
          w_long_next    = 1'b1;
          w_rep_cnt_next = '0;
        end else begin
          w_hold_cnt_next = r_hold_cnt + HOLD_W'(1);
        end
      end
      S_LONG: begin
        if (!r_btn_s) begin
          w_state_next  = S_DB_RELEASE;
          w_ret_next    = S_LONG;
          w_db_cnt_next = '0;
        end else if (r_rep_cnt == REP_W'(REPEAT_CYCLES - 1)) begin
          w_repeat_next  = 1'b1;
          w_rep_cnt_next = '0;
        end else begin
          w_rep_cnt_next = r_rep_cnt + REP_W'(1);
        end
      end
      S_DB_RELEASE: begin
        // Bounce during release resumes the hold with its counters untouched.
        if (r_btn_s) begin
          w_state_next = r_ret;
        end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          w_state_next = S_IDLE;
          w_level_next = 1'b0;
        end else begin
          w_db_cnt_next = r_db_cnt + DB_W'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign btn_level    = r_level;
  assign press_pulse  = r_press;
  assign long_pulse   = r_long;
  assign repeat_pulse = r_repeat;
  assign press_count  = r_count;

endmodule
